// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg -- shared definitions for the load/store unit.
//   * lsu_state_e   : memory-access FSM states (LSU_IDLE / LSU_REQ / LSU_WAIT)
//   * LSU_SEL_*     : funct3 access-size encodings carried on byte_sel
//   * LSU_EXC_*     : misaligned-access exception codes
//   * lsu_stage_t   : contents of the IEX->LSU stage register
//   * lsu_misaligned: natural-alignment test used when LSU_MISALIGN_CHK_EN is set
// -----------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2
    } lsu_state_e;

    localparam logic [2:0] LSU_SEL_B  = 3'b000;
    localparam logic [2:0] LSU_SEL_H  = 3'b001;
    localparam logic [2:0] LSU_SEL_W  = 3'b010;
    localparam logic [2:0] LSU_SEL_BU = 3'b100;
    localparam logic [2:0] LSU_SEL_HU = 3'b101;

    localparam logic [3:0] LSU_EXC_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] LSU_EXC_STORE_MISALIGN = 4'd6;

    typedef struct packed {
        logic        valid;
        logic        rf_we;
        logic        rf_rd_sel1;
        logic        mem_we;
        logic        mem_re;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic [2:0]  byte_sel;
        logic [31:0] dout;
        logic [31:0] rf_rd2;
    } lsu_stage_t;

    // Unlisted byte_sel encodings are treated as word accesses, matching lsu_align.
    function automatic logic lsu_misaligned(input logic [2:0] sel, input logic [1:0] off);
        case (sel)
            LSU_SEL_B, LSU_SEL_BU: return 1'b0;
            LSU_SEL_H, LSU_SEL_HU: return off[0];
            default:               return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align -- combinational data alignment for the LSU.
//   byte_sel  in  3   access size (funct3)
//   addr_lo   in  2   byte offset within the word
//   st_data   in  32  raw store data
//   rsp_data  in  32  raw word returned by memory
//   wstrb     out 4   byte-lane write strobes
//   wdata     out 32  store data replicated across lanes
//   ld_data   out 32  selected lane(s), sign- or zero-extended
// Offsets that overrun the word are truncated to the 4 lanes.
// -----------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  byte_sel,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic [31:0] rsp_data,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    // Bring the addressed lane down to bit 0 before extracting.
    assign shifted = rsp_data >> {addr_lo, 3'b000};

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        wstrb   = 4'b1111;
        wdata   = st_data;
        ld_data = rsp_data;
        case (byte_sel)
            LSU_SEL_B: begin
                wstrb   = 4'b0001 << addr_lo;
                wdata   = {4{st_data[7:0]}};
                ld_data = {{24{shifted[7]}}, shifted[7:0]};
            end
            LSU_SEL_BU: begin
                wstrb   = 4'b0001 << addr_lo;
                wdata   = {4{st_data[7:0]}};
                ld_data = {24'd0, shifted[7:0]};
            end
            LSU_SEL_H: begin
                wstrb   = 4'b0011 << addr_lo;
                wdata   = {2{st_data[15:0]}};
                ld_data = {{16{shifted[15]}}, shifted[15:0]};
            end
            LSU_SEL_HU: begin
                wstrb   = 4'b0011 << addr_lo;
                wdata   = {2{st_data[15:0]}};
                ld_data = {16'd0, shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu -- load/store pipeline stage between IEX and WB.
//   clk, rstn                 clock, asynchronous active-low reset
//   iex2lsu_*                 executed instruction (qualifiers, pc/inst/rd,
//                             byte_sel, ALU result dout, store data rf_rd2)
//   ac2lsu_flush/_stall       hazard-controller kill / hold
//   lsu2mem_* / mem2lsu_*     single-outstanding memory request/response port
//   lsu2wb_*                  writeback outputs
//   lsu2ac_hazard             high while a memory access is in flight
//   lsu_except_*              misaligned-access exception (code 4 load, 6 store)
// Optional feature: define LSU_MISALIGN_CHK_EN to trap misaligned half/word
// accesses instead of issuing them.
// -----------------------------------------------------------------------------
module lsu
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,

    input  logic        iex2lsu_valid,
    input  logic        iex2lsu_rf_we,
    input  logic        iex2lsu_rf_rd_sel1,
    input  logic        iex2lsu_mem_we,
    input  logic        iex2lsu_mem_re,
    input  logic [31:0] iex2lsu_pc,
    input  logic [31:0] iex2lsu_inst,
    input  logic [4:0]  iex2lsu_rd,
    input  logic [2:0]  iex2lsu_mem_byte_sel,
    input  logic [31:0] iex2lsu_dout,
    input  logic [31:0] iex2lsu_rf_rd2,

    input  logic        ac2lsu_flush,
    input  logic        ac2lsu_stall,

    output logic        lsu2mem_req_valid,
    input  logic        mem2lsu_req_ready,
    output logic [31:0] lsu2mem_addr,
    output logic        lsu2mem_we,
    output logic [31:0] lsu2mem_wdata,
    output logic [3:0]  lsu2mem_wstrb,
    input  logic        mem2lsu_rsp_valid,
    input  logic [31:0] mem2lsu_rsp_data,

    output logic        lsu2wb_valid,
    output logic        lsu2wb_rf_we,
    output logic [31:0] lsu2wb_pc,
    output logic [31:0] lsu2wb_inst,
    output logic [4:0]  lsu2wb_rd,
    output logic [31:0] lsu2wb_dout,

    output logic        lsu2ac_hazard,
    output logic        lsu_except_valid,
    output logic [3:0]  lsu_except_code
);

    lsu_state_e  state;
    lsu_stage_t  stg;
    lsu_stage_t  in_stage;
    logic        req_valid_q;
    logic        mem_done_q;
    logic [31:0] load_q;

    logic        capture;
    logic        in_mem;
    logic        in_misalign;
    logic        start_ok;
    logic        handshake;

    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata;
    logic [31:0] al_ld_data;

    assign in_stage = '{
        valid:      iex2lsu_valid,
        rf_we:      iex2lsu_rf_we,
        rf_rd_sel1: iex2lsu_rf_rd_sel1,
        mem_we:     iex2lsu_mem_we,
        mem_re:     iex2lsu_mem_re,
        pc:         iex2lsu_pc,
        inst:       iex2lsu_inst,
        rd:         iex2lsu_rd,
        byte_sel:   iex2lsu_mem_byte_sel,
        dout:       iex2lsu_dout,
        rf_rd2:     iex2lsu_rf_rd2
    };

    // Writeback source is chosen by mem_re; rf_rd_sel1 is carried but not consumed here.
    logic unused_rd_sel1;
    assign unused_rd_sel1 = stg.rf_rd_sel1;

    assign lsu2ac_hazard = (state != LSU_IDLE);
    assign capture       = ~(ac2lsu_stall | lsu2ac_hazard);
    assign in_mem        = iex2lsu_valid & (iex2lsu_mem_re | iex2lsu_mem_we);
    assign handshake     = req_valid_q & mem2lsu_req_ready;

`ifdef LSU_MISALIGN_CHK_EN
    logic       except_valid_q;
    logic [3:0] except_code_q;
    logic       start_bad;

    assign in_misalign      = lsu_misaligned(iex2lsu_mem_byte_sel, iex2lsu_dout[1:0]);
    assign start_bad        = capture & ~ac2lsu_flush & in_mem & in_misalign;
    assign lsu_except_valid = except_valid_q;
    assign lsu_except_code  = except_code_q;
`else
    assign in_misalign      = 1'b0;
    assign lsu_except_valid = 1'b0;
    assign lsu_except_code  = 4'd0;
`endif

    assign start_ok = capture & ~ac2lsu_flush & in_mem & ~in_misalign;

    lsu_align u_align (
        .byte_sel (stg.byte_sel),
        .addr_lo  (stg.dout[1:0]),
        .st_data  (stg.rf_rd2),
        .rsp_data (mem2lsu_rsp_data),
        .wstrb    (al_wstrb),
        .wdata    (al_wdata),
        .ld_data  (al_ld_data)
    );

    // Stage register, access FSM and result register. The stage holds while
    // hazard is high, so the request fields stay stable without extra flops.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: every register here, stage payload included, is reset so outputs are 0 out of reset.
        if (!rstn) begin
            state       <= LSU_IDLE;
            stg         <= '0;
            req_valid_q <= 1'b0;
            mem_done_q  <= 1'b0;
            load_q      <= '0;
`ifdef LSU_MISALIGN_CHK_EN
            except_valid_q <= 1'b0;
            except_code_q  <= 4'd0;
`endif
        end else begin
            // NOTE: non-blocking assignments only; the later flush assignment overrides the capture.
            if (capture) begin
                stg        <= in_stage;
                mem_done_q <= 1'b0;
            end
            if (ac2lsu_flush) begin
                stg.valid <= 1'b0;
            end

`ifdef LSU_MISALIGN_CHK_EN
            // One-cycle pulse on the capture of a misaligned access.
            except_valid_q <= start_bad;
            except_code_q  <= !start_bad      ? 4'd0 :
                              iex2lsu_mem_we  ? LSU_EXC_STORE_MISALIGN
                                              : LSU_EXC_LOAD_MISALIGN;
`endif

            case (state)
                LSU_IDLE: begin
                    if (start_ok) begin
                        state       <= LSU_REQ;
                        req_valid_q <= 1'b1;
                    end
                end
                LSU_REQ: begin
                    if (handshake) begin
                        // Once accepted the access must complete, flushed or not.
                        req_valid_q <= 1'b0;
                        if (mem2lsu_rsp_valid) begin
                            state      <= LSU_IDLE;
                            mem_done_q <= 1'b1;
                            load_q     <= al_ld_data;
                        end else begin
                            state <= LSU_WAIT;
                        end
                    end else if (ac2lsu_flush) begin
                        state       <= LSU_IDLE;
                        req_valid_q <= 1'b0;
                    end
                end
                LSU_WAIT: begin
                    // A flush here only clears stg.valid; the response is still drained.
                    if (mem2lsu_rsp_valid) begin
                        state      <= LSU_IDLE;
                        mem_done_q <= 1'b1;
                        load_q     <= al_ld_data;
                    end
                end
                default: begin
                    state       <= LSU_IDLE;
                    req_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Memory port: fields are forced to 0 outside an active request.
    assign lsu2mem_req_valid = req_valid_q;
    assign lsu2mem_addr      = req_valid_q ? {stg.dout[31:2], 2'b00} : 32'd0;
    assign lsu2mem_we        = req_valid_q & stg.mem_we;
    assign lsu2mem_wstrb     = (req_valid_q & stg.mem_we) ? al_wstrb : 4'd0;
    assign lsu2mem_wdata     = (req_valid_q & stg.mem_we) ? al_wdata : 32'd0;

    // Writeback: ALU results pass straight from the stage register; memory
    // instructions wait for mem_done_q (never set for a trapped access).
    assign lsu2wb_valid = stg.valid & ~lsu2ac_hazard & (~(stg.mem_re | stg.mem_we) | mem_done_q);
    assign lsu2wb_rf_we = lsu2wb_valid & stg.rf_we;
    assign lsu2wb_pc    = stg.pc;
    assign lsu2wb_inst  = stg.inst;
    assign lsu2wb_rd    = stg.rd;
    assign lsu2wb_dout  = stg.mem_re ? load_q : stg.dout;

endmodule

// File: tb/tb_lsu.sv
// -----------------------------------------------------------------------------
// tb_lsu -- self-checking bench for lsu. Directed scenarios followed by a
// randomized access loop; expected values come from arithmetic reference
// functions below. Inputs change on the falling edge, outputs are sampled
// there too, away from the rising edge.
// -----------------------------------------------------------------------------
module tb_lsu;

    logic        clk = 1'b0;
    logic        rstn;
    logic        iex2lsu_valid, iex2lsu_rf_we, iex2lsu_rf_rd_sel1, iex2lsu_mem_we, iex2lsu_mem_re;
    logic [31:0] iex2lsu_pc, iex2lsu_inst, iex2lsu_dout, iex2lsu_rf_rd2;
    logic [4:0]  iex2lsu_rd;
    logic [2:0]  iex2lsu_mem_byte_sel;
    logic        ac2lsu_flush, ac2lsu_stall;
    logic        lsu2mem_req_valid, mem2lsu_req_ready, lsu2mem_we;
    logic [31:0] lsu2mem_addr, lsu2mem_wdata;
    logic [3:0]  lsu2mem_wstrb;
    logic        mem2lsu_rsp_valid;
    logic [31:0] mem2lsu_rsp_data;
    logic        lsu2wb_valid, lsu2wb_rf_we;
    logic [31:0] lsu2wb_pc, lsu2wb_inst, lsu2wb_dout;
    logic [4:0]  lsu2wb_rd;
    logic        lsu2ac_hazard, lsu_except_valid;
    logic [3:0]  lsu_except_code;

    int checks = 0;
    int passes = 0;

    lsu dut (
        .clk(clk), .rstn(rstn),
        .iex2lsu_valid(iex2lsu_valid), .iex2lsu_rf_we(iex2lsu_rf_we),
        .iex2lsu_rf_rd_sel1(iex2lsu_rf_rd_sel1), .iex2lsu_mem_we(iex2lsu_mem_we),
        .iex2lsu_mem_re(iex2lsu_mem_re), .iex2lsu_pc(iex2lsu_pc), .iex2lsu_inst(iex2lsu_inst),
        .iex2lsu_rd(iex2lsu_rd), .iex2lsu_mem_byte_sel(iex2lsu_mem_byte_sel),
        .iex2lsu_dout(iex2lsu_dout), .iex2lsu_rf_rd2(iex2lsu_rf_rd2),
        .ac2lsu_flush(ac2lsu_flush), .ac2lsu_stall(ac2lsu_stall),
        .lsu2mem_req_valid(lsu2mem_req_valid), .mem2lsu_req_ready(mem2lsu_req_ready),
        .lsu2mem_addr(lsu2mem_addr), .lsu2mem_we(lsu2mem_we), .lsu2mem_wdata(lsu2mem_wdata),
        .lsu2mem_wstrb(lsu2mem_wstrb), .mem2lsu_rsp_valid(mem2lsu_rsp_valid),
        .mem2lsu_rsp_data(mem2lsu_rsp_data),
        .lsu2wb_valid(lsu2wb_valid), .lsu2wb_rf_we(lsu2wb_rf_we), .lsu2wb_pc(lsu2wb_pc),
        .lsu2wb_inst(lsu2wb_inst), .lsu2wb_rd(lsu2wb_rd), .lsu2wb_dout(lsu2wb_dout),
        .lsu2ac_hazard(lsu2ac_hazard), .lsu_except_valid(lsu_except_valid),
        .lsu_except_code(lsu_except_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // ---------------- reference model (plain arithmetic) ----------------
    function automatic logic [3:0] m_wstrb(input logic [2:0] sel, input logic [1:0] off);
        if (sel == 3'b000) return 4'(32'd1 << off);
        if (sel == 3'b001) return 4'(32'd3 << off);
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] sel, input logic [31:0] d);
        if (sel == 3'b000) return (d & 32'hFF) * 32'h0101_0101;
        if (sel == 3'b001) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] sel, input logic [1:0] off,
                                           input logic [31:0] rsp);
        logic [31:0] sh, v;
        sh = rsp >> (8 * int'(off));
        case (sel)
            3'b000: begin v = sh & 32'hFF;   if (v >= 32'h80)   v = v - 32'h100;   end
            3'b100:       v = sh & 32'hFF;
            3'b001: begin v = sh & 32'hFFFF; if (v >= 32'h8000) v = v - 32'h10000; end
            3'b101:       v = sh & 32'hFFFF;
            default:      v = rsp;
        endcase
        return v;
    endfunction

    // ---------------- drivers ----------------
    task automatic drive_inst(input bit mem, input bit st, input logic [2:0] sel,
                              input logic [31:0] dout, input logic [31:0] rd2);
        iex2lsu_valid        = 1'b1;
        iex2lsu_rf_we        = !(mem && st);
        iex2lsu_rf_rd_sel1   = 1'($urandom);
        iex2lsu_mem_we       = mem && st;
        iex2lsu_mem_re       = mem && !st;
        iex2lsu_pc           = $urandom;
        iex2lsu_inst         = $urandom;
        iex2lsu_rd           = 5'($urandom);
        iex2lsu_mem_byte_sel = sel;
        iex2lsu_dout         = dout;
        iex2lsu_rf_rd2       = rd2;
    endtask

    task automatic run_alu(input string tag, input logic [31:0] v);
        logic [31:0] e_pc, e_inst;
        logic [4:0]  e_rd;
        drive_inst(1'b0, 1'b0, 3'b010, v, 32'd0);
        e_pc = iex2lsu_pc; e_inst = iex2lsu_inst; e_rd = iex2lsu_rd;
        @(negedge clk);
        iex2lsu_valid = 1'b0;
        check({tag, ".wb_valid"}, lsu2wb_valid, 1);
        check({tag, ".rf_we"},    lsu2wb_rf_we, 1);
        check({tag, ".dout"},     lsu2wb_dout, v);
        check({tag, ".pc"},       lsu2wb_pc, e_pc);
        check({tag, ".inst"},     lsu2wb_inst, e_inst);
        check({tag, ".rd"},       lsu2wb_rd, 32'(e_rd));
        check({tag, ".hazard"},   lsu2ac_hazard, 0);
        @(negedge clk);
        check({tag, ".wb_pulse"}, lsu2wb_valid, 0);
    endtask

    // Full access with a given ready delay and response delay after handshake.
    task automatic run_access(input string tag, input bit st, input logic [2:0] sel,
                              input logic [31:0] addr, input logic [31:0] sdata,
                              input logic [31:0] rsp, input int rdy_dly, input int rsp_dly,
                              input logic [3:0] e_strb, input logic [31:0] e_wdata,
                              input logic [31:0] e_load);
        logic [4:0] e_rd;
        drive_inst(1'b1, st, sel, addr, sdata);
        e_rd = iex2lsu_rd;
        @(negedge clk);
        iex2lsu_valid = 1'b0;
        for (int i = 0; i <= rdy_dly; i++) begin
            check({tag, ".req_valid"}, lsu2mem_req_valid, 1);
            check({tag, ".hazard"},    lsu2ac_hazard, 1);
            check({tag, ".wb_hold"},   lsu2wb_valid, 0);
            check({tag, ".addr"},      lsu2mem_addr, addr & 32'hFFFF_FFFC);
            check({tag, ".we"},        lsu2mem_we, 32'(st));
            check({tag, ".except"},    lsu_except_valid, 0);
            if (st) begin
                check({tag, ".wstrb"}, lsu2mem_wstrb, 32'(e_strb));
                check({tag, ".wdata"}, lsu2mem_wdata, e_wdata);
            end
            if (i == rdy_dly) begin
                mem2lsu_req_ready = 1'b1;
                if (rsp_dly == 0) begin
                    mem2lsu_rsp_valid = 1'b1;
                    mem2lsu_rsp_data  = rsp;
                end
            end
            @(negedge clk);
        end
        mem2lsu_req_ready = 1'b0;
        for (int i = 1; i <= rsp_dly; i++) begin
            check({tag, ".wait_req"},    lsu2mem_req_valid, 0);
            check({tag, ".wait_hazard"}, lsu2ac_hazard, 1);
            if (i == rsp_dly) begin
                mem2lsu_rsp_valid = 1'b1;
                mem2lsu_rsp_data  = rsp;
            end
            @(negedge clk);
        end
        mem2lsu_rsp_valid = 1'b0;
        mem2lsu_rsp_data  = $urandom;
        check({tag, ".done_hazard"}, lsu2ac_hazard, 0);
        check({tag, ".wb_valid"},    lsu2wb_valid, 1);
        check({tag, ".wb_rf_we"},    lsu2wb_rf_we, 32'(!st));
        check({tag, ".wb_rd"},       lsu2wb_rd, 32'(e_rd));
        if (!st) check({tag, ".load"}, lsu2wb_dout, e_load);
        @(negedge clk);
        check({tag, ".wb_pulse"}, lsu2wb_valid, 0);
    endtask

    // ---------------- stimulus ----------------
    logic [2:0]  sel_tab [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0]  r_sel;
    logic [31:0] r_addr, r_sd, r_rsp;
    bit          r_st;

    initial begin
        rstn = 1'b0;
        iex2lsu_valid = 0; iex2lsu_rf_we = 0; iex2lsu_rf_rd_sel1 = 0;
        iex2lsu_mem_we = 0; iex2lsu_mem_re = 0; iex2lsu_pc = 0; iex2lsu_inst = 0;
        iex2lsu_rd = 0; iex2lsu_mem_byte_sel = 0; iex2lsu_dout = 0; iex2lsu_rf_rd2 = 0;
        ac2lsu_flush = 0; ac2lsu_stall = 0;
        mem2lsu_req_ready = 0; mem2lsu_rsp_valid = 0; mem2lsu_rsp_data = 0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst.req_valid", lsu2mem_req_valid, 0);
        check("rst.wb_valid",  lsu2wb_valid, 0);
        check("rst.hazard",    lsu2ac_hazard, 0);
        check("rst.except",    lsu_except_valid, 0);
        check("rst.wb_dout",   lsu2wb_dout, 0);
        check("rst.wb_pc",     lsu2wb_pc, 0);
        check("rst.addr",      lsu2mem_addr, 0);
        check("rst.wstrb",     lsu2mem_wstrb, 0);
        rstn = 1'b1;
        @(negedge clk);

        run_alu("alu1", 32'h0000_1234);

        // Word store, ready immediately, response next cycle: hazard two cycles
        run_access("sw", 1'b1, 3'b010, 32'h100, 32'hAABB_CCDD, 32'h0, 0, 1,
                   4'b1111, 32'hAABB_CCDD, 32'h0);
        // Byte store with response in the handshake cycle
        run_access("sb", 1'b1, 3'b000, 32'h103, 32'h0000_00EE, 32'h0, 0, 0,
                   4'b1000, 32'hEEEE_EEEE, 32'h0);
        run_access("lb",  1'b0, 3'b000, 32'h102, 32'h0, 32'h80FF_7F00, 0, 1,
                   4'h0, 32'h0, 32'hFFFF_FFFF);
        run_access("lbu", 1'b0, 3'b100, 32'h102, 32'h0, 32'h80FF_7F00, 1, 0,
                   4'h0, 32'h0, 32'h0000_00FF);
        // Half load, ready after 3 cycles, response 2 cycles later
        run_access("lh",  1'b0, 3'b001, 32'h202, 32'h0, 32'h8001_1234, 3, 2,
                   4'h0, 32'h0, 32'hFFFF_8001);

        // Flush together with capture: nothing issues
        drive_inst(1'b1, 1'b0, 3'b010, 32'h400, 32'h0);
        ac2lsu_flush = 1'b1;
        @(negedge clk);
        ac2lsu_flush = 1'b0; iex2lsu_valid = 1'b0;
        check("flush_idle.req", lsu2mem_req_valid, 0);
        check("flush_idle.haz", lsu2ac_hazard, 0);
        check("flush_idle.wb",  lsu2wb_valid, 0);
        @(negedge clk);
        check("flush_idle.req2", lsu2mem_req_valid, 0);

        // Flush in REQ before handshake
        drive_inst(1'b1, 1'b0, 3'b010, 32'h404, 32'h0);
        @(negedge clk);
        iex2lsu_valid = 1'b0;
        check("flush_req.pre", lsu2mem_req_valid, 1);
        ac2lsu_flush = 1'b1;
        @(negedge clk);
        ac2lsu_flush = 1'b0;
        check("flush_req.req", lsu2mem_req_valid, 0);
        check("flush_req.haz", lsu2ac_hazard, 0);
        check("flush_req.wb",  lsu2wb_valid, 0);

        // Flush in WAIT: response drained, no writeback, then ADD 5
        drive_inst(1'b1, 1'b0, 3'b010, 32'h408, 32'h0);
        @(negedge clk);
        iex2lsu_valid = 1'b0; mem2lsu_req_ready = 1'b1;
        @(negedge clk);
        mem2lsu_req_ready = 1'b0;
        check("flush_wait.in_wait", lsu2ac_hazard, 1);
        ac2lsu_flush = 1'b1;
        @(negedge clk);
        ac2lsu_flush = 1'b0;
        check("flush_wait.drain", lsu2ac_hazard, 1);
        mem2lsu_rsp_valid = 1'b1; mem2lsu_rsp_data = 32'h1111_2222;
        @(negedge clk);
        mem2lsu_rsp_valid = 1'b0;
        check("flush_wait.idle", lsu2ac_hazard, 0);
        check("flush_wait.wb",   lsu2wb_valid, 0);
        run_alu("add5", 32'h5);

        // Stall with simultaneous response: result held until stall drops
        drive_inst(1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
        @(negedge clk);
        iex2lsu_valid = 1'b0; mem2lsu_req_ready = 1'b1;
        @(negedge clk);
        mem2lsu_req_ready = 1'b0;
        ac2lsu_stall = 1'b1; mem2lsu_rsp_valid = 1'b1; mem2lsu_rsp_data = 32'hCAFE_F00D;
        drive_inst(1'b0, 1'b0, 3'b010, 32'h77, 32'h0);
        @(negedge clk);
        mem2lsu_rsp_valid = 1'b0; mem2lsu_rsp_data = 32'h0;
        check("stall.haz",   lsu2ac_hazard, 0);
        check("stall.held1", lsu2wb_dout, 32'hCAFE_F00D);
        @(negedge clk);
        check("stall.held2", lsu2wb_dout, 32'hCAFE_F00D);
        ac2lsu_stall = 1'b0;
        @(negedge clk);
        iex2lsu_valid = 1'b0;
        check("stall.next_valid", lsu2wb_valid, 1);
        check("stall.next_dout",  lsu2wb_dout, 32'h77);
        @(negedge clk);

        // Reset during WAIT: access abandoned, late response ignored
        drive_inst(1'b1, 1'b0, 3'b010, 32'h500, 32'h0);
        @(negedge clk);
        iex2lsu_valid = 1'b0; mem2lsu_req_ready = 1'b1;
        @(negedge clk);
        mem2lsu_req_ready = 1'b0;
        check("rst_wait.pre", lsu2ac_hazard, 1);
        #2 rstn = 1'b0;
        #1;
        check("rst_wait.haz", lsu2ac_hazard, 0);
        check("rst_wait.req", lsu2mem_req_valid, 0);
        @(negedge clk);
        rstn = 1'b1;
        mem2lsu_rsp_valid = 1'b1; mem2lsu_rsp_data = 32'hDEAD_BEEF;
        @(negedge clk);
        mem2lsu_rsp_valid = 1'b0;
        check("rst_wait.late_haz", lsu2ac_hazard, 0);
        check("rst_wait.late_wb",  lsu2wb_valid, 0);
        check("rst_wait.late_req", lsu2mem_req_valid, 0);

`ifdef LSU_MISALIGN_CHK_EN
        drive_inst(1'b1, 1'b0, 3'b010, 32'h102, 32'h0);
        @(negedge clk);
        iex2lsu_valid = 1'b0;
        check("mis_lw.req",    lsu2mem_req_valid, 0);
        check("mis_lw.except", lsu_except_valid, 1);
        check("mis_lw.code",   lsu_except_code, 4);
        check("mis_lw.wb",     lsu2wb_valid, 0);
        @(negedge clk);
        check("mis_lw.pulse",  lsu_except_valid, 0);
        drive_inst(1'b1, 1'b1, 3'b001, 32'h101, 32'h1234);
        @(negedge clk);
        iex2lsu_valid = 1'b0;
        check("mis_sh.req",    lsu2mem_req_valid, 0);
        check("mis_sh.except", lsu_except_valid, 1);
        check("mis_sh.code",   lsu_except_code, 6);
        @(negedge clk);
`else
        // Misaligned word load proceeds on the truncated word address
        run_access("mis_lw", 1'b0, 3'b010, 32'h102, 32'h0, 32'h1357_2468, 0, 1,
                   4'h0, 32'h0, 32'h1357_2468);
        run_access("mis_sh", 1'b1, 3'b001, 32'h103, 32'h0000_BEEF, 32'h0, 1, 1,
                   4'b1000, 32'hBEEF_BEEF, 32'h0);
`endif

        // Randomized accesses against the reference model
        for (int n = 0; n < 24; n++) begin
            r_st  = 1'($urandom);
            r_sel = sel_tab[$urandom_range(0, 4)];
            if (r_st) r_sel[2] = 1'b0;
            r_addr = $urandom;
`ifdef LSU_MISALIGN_CHK_EN
            if (r_sel[1:0] == 2'b01) r_addr[0] = 1'b0;
            if (r_sel[1:0] == 2'b10) r_addr[1:0] = 2'b00;
`endif
            r_sd  = $urandom;
            r_rsp = $urandom;
            run_access("rand", r_st, r_sel, r_addr, r_sd, r_rsp,
                       $urandom_range(0, 3), $urandom_range(0, 2),
                       m_wstrb(r_sel, r_addr[1:0]), m_wdata(r_sel, r_sd),
                       m_load(r_sel, r_addr[1:0], r_rsp));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
